wb_commit_stage: RTL
====================

// Module: wb_commit_stage
// PURPOSE
//  MEM/WB pipeline stage feeding the register-file write port. Accepts retiring instructions from MEM
//  (valid/ready), buffers them in a small in-order queue, resolves destination (rd vs rt) and result
//  (ALU vs load data), and drives write_data/write_reg/signal_regWrite into the register file.
//  Also exposes the head entry as a forwarding source and counts retired instructions.
// PARAMETERS
//  DATA_W      32  datapath width
//  REG_ADDR_W  5   register index width
//  DEPTH       2   queue entries (power of two, >=2)
//  CNT_W       16  width of retire counter
// PORTS
//  clk              in   1           rising-edge clock
//  reset            in   1           asynchronous, active-high reset
//  in_valid         in   1           MEM stage presents an instruction
//  in_ready         out  1           stage can accept (queue not full)
//  in_alu_result    in   DATA_W      ALU result
//  in_mem_data      in   DATA_W      load data
//  in_rt, in_rd     in   REG_ADDR_W  candidate destinations
//  in_opcode        in   6           opcode, carried for debug/trace only
//  in_regWrite      in   1           instruction writes a register
//  in_regDst        in   1           1: dest=rd, 0: dest=rt
//  in_memToReg      in   1           1: data=mem_data, 0: alu_result
//  flush            in   1           discard all queued entries
//  wb_ready         in   1           register file accepts a write this cycle
//  write_data       out  DATA_W      to register file
//  write_reg        out  REG_ADDR_W  to register file
//  signal_regWrite  out  1           write strobe, one cycle per committed write
//  wb_opcode        out  6           opcode of head entry
//  fwd_valid        out  1           head holds a pending register write
//  fwd_reg, fwd_data out REG_ADDR_W / DATA_W  forwarding value (== write_reg/write_data)
//  retired_count    out  CNT_W       instructions retired since reset
// BEHAVIOUR
//  - Reset (async): queue empty, count=0, all outputs 0, in_ready=1 immediately on release.
//  - Push: in_valid && in_ready && !flush. Dest and data resolved at push; entry stores
//    {data, dest, opcode, wr}, wr = in_regWrite && dest!=0 (writes to r0 suppressed).
//  - in_ready = (count < DEPTH), combinational from registered count; no push when full.
//  - Head outputs are registered state: accepted instr appears on write_* one cycle after accept.
//  - signal_regWrite = head_valid && head.wr. fwd_valid identical.
//  - Pop: head_valid && (!head.wr || wb_ready). Non-writing entries retire in one cycle
//    without wb_ready; writing entries hold (stall) until wb_ready=1.
//  - Simultaneous push+pop: allowed at any count, count unchanged, order preserved;
//    at count==DEPTH push is blocked even if a pop occurs that cycle.
//  - retired_count += 1 per pop, wraps modulo 2^CNT_W.
//  - flush: highest priority; next edge count=0, pointers 0, same-cycle push dropped,
//    same-cycle pop still counted only if head.wr && wb_ready (write already strobed).
//  - When empty: write_data/write_reg/wb_opcode hold last-popped values, strobes 0.
//  - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
// STRUCTURE
//  - Shared package: wb_entry_t struct {data, dest, opcode, wr}, opcode constants (R-type, LW, SW,
//    BEQ), DATA_W/REG_ADDR_W defaults.
//  - One sub-module: wb_queue (generic DEPTH-entry FIFO of wb_entry_t with push/pop/flush,
//    count, head). Top level holds resolve logic, pop decision, counter.
// TESTING
//  1. Reset mid-stream with 2 entries queued -> next cycle count=0, signal_regWrite=0, in_ready=1,
//     retired_count=0.
//  2. Push R-type rd=5, alu=0x0000_00AA, regDst=1, wb_ready=1 -> next cycle write_reg=5,
//     write_data=0xAA, signal_regWrite=1 for exactly one cycle; retired_count=1.
//  3. Push LW rt=9, memToReg=1, mem_data=0xDEAD_BEEF, wb_ready=0 for 3 cycles -> strobe held,
//     fwd_reg=9; second push accepted, third blocked (in_ready=0); releases in order on wb_ready.
//  4. Push regWrite=1 with dest=0, then SW (regWrite=0) -> no strobe for either, each retires
//     in 1 cycle, retired_count +=2.
//  5. Queue full + flush + in_valid same cycle -> next cycle empty, pushed instr lost, no strobe.
//  6. Back-to-back pushes with wb_ready=1, 70000 instrs -> one strobe/cycle, counter wraps to 4464.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// Shared types and constants for the MEM/WB commit stage: entry layout,
// opcode values and the destination/result resolve helper.
package wb_commit_stage_pkg;

   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned OPCODE_W       = 6;

   // Opcodes that reach this stage; carried for trace only, never decoded here.
   localparam logic [OPCODE_W-1:0] OPC_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OPC_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OPC_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OPC_SW    = 6'h2B;

   typedef logic [DATA_W_DEF-1:0]     data_t;
   typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [OPCODE_W-1:0]       opcode_t;

   // One retiring instruction, already resolved to its final destination and value.
   typedef struct packed {
      data_t     data;
      reg_addr_t dest;
      opcode_t   opcode;
      logic      wr;
   } wb_entry_t;

   // Selects rd/rt and ALU/load data; a write to r0 is turned into a non-writing entry.
   function automatic wb_entry_t resolve_entry(
      input data_t     alu_result,
      input data_t     mem_data,
      input reg_addr_t rt,
      input reg_addr_t rd,
      input opcode_t   opcode,
      input logic      reg_write,
      input logic      reg_dst,
      input logic      mem_to_reg
   );
      wb_entry_t e;
      e.dest   = reg_dst    ? rd       : rt;
      e.data   = mem_to_reg ? mem_data : alu_result;
      e.opcode = opcode;
      e.wr     = reg_write && (e.dest != '0);
      return e;
   endfunction

endpackage

// File: rtl/wb_queue.sv
// In-order FIFO of resolved write-back entries with synchronous flush.
// The head entry is read straight from registered storage, so it has no
// combinational path from the push side.
module wb_queue
   import wb_commit_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  wb_entry_t                i_data,
   output wb_entry_t                o_head,
   output logic                     o_head_valid,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_entry_t          r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_do_push;
   logic               w_do_pop;

   // Guard the raw requests so the queue never overruns or underruns on its own.
   assign w_do_push = i_push && !i_flush && (r_count != FULL_CNT);
   assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

   // Pointer and occupancy bookkeeping; flush empties the queue on the next edge.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage write.
   // NOTE: the storage array is deliberately not reset; validity is carried
   // entirely by r_count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head       = r_mem[r_rd_ptr];
   assign o_head_valid = (r_count != '0);
   assign o_count      = r_count;

   a_no_push_when_full : assert property (
      @(posedge clk) disable iff (reset) (i_push && !i_flush) |-> (r_count != FULL_CNT));
   a_no_pop_when_empty : assert property (
      @(posedge clk) disable iff (reset) (i_pop && !i_flush) |-> (r_count != '0));

endmodule

// File: rtl/wb_commit_stage.sv
// MEM/WB commit stage: resolves each retiring instruction, queues it in order,
// presents the head to the register-file write port and as a forwarding source,
// and counts retired instructions.
module wb_commit_stage
   import wb_commit_stage_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned CNT_W      = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_mem_data,
   input  logic [REG_ADDR_W-1:0] in_rt,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [5:0]            in_opcode,
   input  logic                  in_regWrite,
   input  logic                  in_regDst,
   input  logic                  in_memToReg,
   input  logic                  flush,
   input  logic                  wb_ready,
   output logic [DATA_W-1:0]     write_data,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic                  signal_regWrite,
   output logic [5:0]            wb_opcode,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_reg,
   output logic [DATA_W-1:0]     fwd_data,
   output logic [CNT_W-1:0]      retired_count
);

   localparam int unsigned QCNT_W = $clog2(DEPTH) + 1;
   localparam logic [QCNT_W-1:0] DEPTH_CNT = QCNT_W'(DEPTH);

   wb_entry_t          w_in_entry;
   wb_entry_t          w_head;
   wb_entry_t          w_view;
   logic               w_head_valid;
   logic [QCNT_W-1:0]  w_count;
   logic               w_push;
   logic               w_pop;
   logic               w_retire;

   wb_entry_t          r_last;
   logic [CNT_W-1:0]   r_retired;

   // Destination and result are fixed at push time so the queue holds final values.
   always_comb begin
      w_in_entry = resolve_entry(in_alu_result, in_mem_data, in_rt, in_rd,
                                 in_opcode, in_regWrite, in_regDst, in_memToReg);
   end

   // Accept only with room from the registered count; a pop in the same cycle
   // does not open a slot, which keeps in_ready free of any wb_ready path.
   assign in_ready = (w_count < DEPTH_CNT);
   assign w_push   = in_valid && in_ready && !flush;

   // Non-writing entries drain unconditionally; writing entries wait for the file.
   assign w_pop    = w_head_valid && (!w_head.wr || wb_ready);

   // Under flush only a pop whose strobe was actually taken counts as retired.
   assign w_retire = w_pop && (!flush || w_head.wr);

   wb_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_flush      (flush),
      .i_data       (w_in_entry),
      .o_head       (w_head),
      .o_head_valid (w_head_valid),
      .o_count      (w_count)
   );

   // Remember the most recently retired entry so the write port holds steady when empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_last <= '0;
      else if (w_retire) r_last <= w_head;
   end

   // Retire counter, wrapping naturally at its width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + CNT_W'(1);
   end

   // Choose what the write port shows: live head, or the last retired entry.
   // NOTE: w_view gets a default before the conditional so no latch is inferred.
   always_comb begin
      w_view = r_last;
      if (w_head_valid) w_view = w_head;
   end

   assign write_data      = w_view.data;
   assign write_reg       = w_view.dest;
   assign wb_opcode       = w_view.opcode;
   assign signal_regWrite = w_head_valid && w_head.wr;
   assign fwd_valid       = signal_regWrite;
   assign fwd_reg         = write_reg;
   assign fwd_data        = write_data;
   assign retired_count   = r_retired;

endmodule
